// File: rtl/rst_decipher.sv
// rst_decipher: Rotary Substitution Table decryption stage, one plaintext char per valid ciphertext pair.
// Rotation is tracked as an offset k into the loaded table rather than by moving bytes.
module rst_decipher #(
    parameter int NUM_ROWS  = 6,
    parameter int ALPHA_CNT = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [11:0][7:0] key,
    input  logic             ctxt_valid,
    input  logic [15:0]      ctxt_str,
    output logic [7:0]       ptxt_char,
    output logic             ptxt_ready,
    output logic             err_invalid_key,
    output logic             err_invalid_ctxt_char,
    output logic             key_not_installed
);
    typedef enum logic {NO_KEY, KEYED} state_t;

    state_t     state_q;
    logic [7:0] rows_q [NUM_ROWS];
    logic [7:0] cols_q [NUM_ROWS];
    logic [7:0] key_row [NUM_ROWS];
    logic [7:0] key_col [NUM_ROWS];
    logic [2:0] k_q, k_d;
    logic [7:0] ptxt_char_q;
    logic       ptxt_ready_q, err_key_q, err_ctxt_q, kni_q;
    logic       key_ok, row_hit, col_hit;
    logic [2:0] row_p, col_p, ri, ci;
    logic [3:0] row_s, col_s;
    logic [5:0] n;
    logic [7:0] dec_char;

    function automatic logic is_alnum(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h5a) || (c >= 8'h61 && c <= 8'h7a);
    endfunction

    // Odd key positions (from the first character) feed rows, even positions feed columns
    assign key_row = '{key[11], key[1], key[9], key[3], key[7], key[5]};
    assign key_col = '{key[10], key[0], key[8], key[2], key[6], key[4]};

    always_comb begin
        key_ok = 1'b1;
        for (int a = 0; a < 12; a++) begin
            key_ok = key_ok & is_alnum(key[a]);
            for (int b = a + 1; b < 12; b++) key_ok = key_ok & (key[a] != key[b]);
        end
    end

    // Key chars are distinct, so at most one row and one column can match
    always_comb begin
        row_hit = 1'b0;
        col_hit = 1'b0;
        row_p   = 3'd0;
        col_p   = 3'd0;
        for (int p = 0; p < NUM_ROWS; p++) begin
            if (rows_q[p] == ctxt_str[15:8]) begin
                row_hit = 1'b1;
                row_p   = 3'(p);
            end
            if (cols_q[p] == ctxt_str[7:0]) begin
                col_hit = 1'b1;
                col_p   = 3'(p);
            end
        end
    end

    // Stored slot p appears at effective index (p + k) mod 6
    assign row_s    = {1'b0, row_p} + {1'b0, k_q};
    assign col_s    = {1'b0, col_p} + {1'b0, k_q};
    assign ri       = row_s >= 4'd6 ? 3'(row_s - 4'd6) : row_s[2:0];
    assign ci       = col_s >= 4'd6 ? 3'(col_s - 4'd6) : col_s[2:0];
    assign n        = 6'(ri) * 6'd6 + 6'(ci);
    assign dec_char = n < 6'(ALPHA_CNT) ? 8'h61 + 8'(n) : 8'h16 + 8'(n);
    assign k_d      = k_q == 3'd5 ? 3'd0 : k_q + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= NO_KEY;
            rows_q       <= '{default: 8'h00};
            cols_q       <= '{default: 8'h00};
            k_q          <= 3'd0;
            ptxt_char_q  <= 8'h00;
            ptxt_ready_q <= 1'b0;
            err_key_q    <= 1'b0;
            err_ctxt_q   <= 1'b0;
            kni_q        <= 1'b1;
        end else begin
            ptxt_ready_q <= 1'b0;
            err_key_q    <= 1'b0;
            err_ctxt_q   <= 1'b0;
            if (state_q == NO_KEY) begin
                if (key_ok) begin
                    rows_q  <= key_row;
                    cols_q  <= key_col;
                    state_q <= KEYED;
                    kni_q   <= 1'b0;
                end else begin
                    err_key_q <= |key;
                end
            end else if (ctxt_valid) begin
                if (row_hit && col_hit) begin
                    ptxt_char_q  <= dec_char;
                    ptxt_ready_q <= 1'b1;
                    k_q          <= k_d;
                end else begin
                    err_ctxt_q <= 1'b1;
                end
            end
        end
    end

    assign ptxt_char             = ptxt_char_q;
    assign ptxt_ready            = ptxt_ready_q;
    assign err_invalid_key       = err_key_q;
    assign err_invalid_ctxt_char = err_ctxt_q;
    assign key_not_installed     = kni_q;
endmodule

// File: tb/tb_rst_decipher.sv
// tb_rst_decipher: directed and randomized checks of rst_decipher against a rotating-table model.
module tb_rst_decipher;
    logic             clk = 1'b0;
    logic             rst_n;
    logic [11:0][7:0] key;
    logic             ctxt_valid;
    logic [15:0]      ctxt_str;
    logic [7:0]       ptxt_char;
    logic             ptxt_ready, err_invalid_key, err_invalid_ctxt_char, key_not_installed;
    int               n_chk = 0;
    int               n_fail = 0;

    always #5 clk = ~clk;

    rst_decipher dut (
        .clk(clk), .rst_n(rst_n), .key(key), .ctxt_valid(ctxt_valid), .ctxt_str(ctxt_str),
        .ptxt_char(ptxt_char), .ptxt_ready(ptxt_ready), .err_invalid_key(err_invalid_key),
        .err_invalid_ctxt_char(err_invalid_ctxt_char), .key_not_installed(key_not_installed)
    );

    // Model keeps a literal table whose rows/cols are physically rotated right after each decode
    bit          m_keyed;
    byte unsigned m_row[6];
    byte unsigned m_col[6];
    logic [7:0]  m_char;
    bit          e_ready, e_errk, e_errc;

    function automatic bit alnum(logic [7:0] c);
        return (c >= "0" && c <= "9") || (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
    endfunction

    function automatic bit key_valid(logic [11:0][7:0] k);
        int seen[byte unsigned];
        for (int a = 0; a < 12; a++) begin
            if (!alnum(k[a]) || seen.exists(k[a])) return 0;
            seen[k[a]] = 1;
        end
        return 1;
    endfunction

    task automatic model_reset();
        m_keyed = 0;
        m_char  = 8'h00;
        e_ready = 0;
        e_errk  = 0;
        e_errc  = 0;
        m_row   = '{default: 0};
        m_col   = '{default: 0};
    endtask

    task automatic model_step();
        int i, j, n;
        byte unsigned tr, tc;
        e_ready = 0;
        e_errk  = 0;
        e_errc  = 0;
        if (!m_keyed) begin
            if (key_valid(key)) begin
                m_keyed = 1;
                m_row = '{key[11], key[1], key[9], key[3], key[7], key[5]};
                m_col = '{key[10], key[0], key[8], key[2], key[6], key[4]};
            end else begin
                e_errk = (key != '0);
            end
        end else if (ctxt_valid) begin
            i = -1;
            j = -1;
            foreach (m_row[p]) begin
                if (m_row[p] == ctxt_str[15:8]) i = p;
                if (m_col[p] == ctxt_str[7:0]) j = p;
            end
            if (i < 0 || j < 0) begin
                e_errc = 1;
            end else begin
                n = 6 * i + j;
                m_char = 8'(n < 26 ? 97 + n : 48 + n - 26);
                e_ready = 1;
                tr = m_row[5];
                tc = m_col[5];
                for (int p = 5; p > 0; p--) begin
                    m_row[p] = m_row[p-1];
                    m_col[p] = m_col[p-1];
                end
                m_row[0] = tr;
                m_col[0] = tc;
            end
        end
    endtask

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, "_char"}, ptxt_char, m_char);
        chk({tag, "_ready"}, 8'(ptxt_ready), 8'(e_ready));
        chk({tag, "_errkey"}, 8'(err_invalid_key), 8'(e_errk));
        chk({tag, "_errctxt"}, 8'(err_invalid_ctxt_char), 8'(e_errc));
        chk({tag, "_nokey"}, 8'(key_not_installed), 8'(!m_keyed));
    endtask

    task automatic step(bit v, logic [15:0] c, string tag);
        ctxt_valid = v;
        ctxt_str   = c;
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    // Asserts reset mid-cycle and checks outputs clear without waiting for a clock edge
    task automatic do_reset(string tag);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic install(logic [11:0][7:0] k);
        key = k;
        step(1'b1, "KL", "install");
        key = '0;
    endtask

    function automatic logic [11:0][7:0] rand_key();
        byte unsigned pool[$];
        logic [11:0][7:0] k;
        int idx;
        for (int c = 0; c < 26; c++) begin
            pool.push_back(8'("A" + c));
            pool.push_back(8'("a" + c));
        end
        for (int c = 0; c < 10; c++) pool.push_back(8'("0" + c));
        for (int a = 0; a < 12; a++) begin
            idx = $urandom_range(0, pool.size() - 1);
            k[a] = pool[idx];
            pool.delete(idx);
        end
        return k;
    endfunction

    logic [15:0] hello_c[5] = '{"KL", "GJ", "GJ", "ED", "EF"};
    logic [7:0]  hello_p[5] = '{"h", "e", "l", "l", "o"};
    logic [7:0]  wrap_p[7]  = '{"a", "h", "o", "v", "2", "9", "a"};
    logic [7:0]  bad_chars[8] = '{"?", "*", "-", ".", " ", "@", "[", "{"};

    initial begin
        logic [11:0][7:0] k;
        logic [7:0] pc, ep;
        int n;
        rst_n = 1'b1;
        key = '0;
        ctxt_valid = 1'b0;
        ctxt_str = '0;
        @(negedge clk);
        do_reset("reset0");

        step(1'b1, "KL", "nokey_idle");
        chk("nokey_ready", 8'(ptxt_ready), 8'd0);
        key = "ABC?*-.HIJKL";
        step(1'b1, "KL", "badkey1");
        chk("badkey1_err", 8'(err_invalid_key), 8'd1);
        key = "ABCDEFGHDDKL";
        step(1'b1, "KL", "badkey2");
        chk("badkey2_err", 8'(err_invalid_key), 8'd1);
        chk("badkey2_nokey", 8'(key_not_installed), 8'd1);
        chk("badkey2_ready", 8'(ptxt_ready), 8'd0);
        install("ABCDEFGHIJKL");
        chk("install_nokey", 8'(key_not_installed), 8'd0);
        chk("install_ready", 8'(ptxt_ready), 8'd0);
        for (int s = 0; s < 5; s++) begin
            step(1'b1, hello_c[s], "hello");
            chk("hello_exp", ptxt_char, hello_p[s]);
        end
        step(1'b0, "KL", "idle");

        do_reset("reset1");
        install("ABCDEFGHIJKL");
        for (int s = 0; s < 7; s++) begin
            step(1'b1, "AB", "wrap");
            chk("wrap_exp", ptxt_char, wrap_p[s]);
        end

        do_reset("reset2");
        install("ABCDEFGHIJKL");
        step(1'b1, "A?", "miss");
        chk("miss_err", 8'(err_invalid_ctxt_char), 8'd1);
        step(1'b1, "BA", "swap");
        chk("swap_err", 8'(err_invalid_ctxt_char), 8'd1);
        step(1'b1, "KL", "after_err");
        chk("after_err_exp", ptxt_char, "h");

        // Chained: ciphertext produced by encrypting with the same rotating table
        do_reset("reset3");
        install("abcdefghijkl");
        for (int c = 0; c < 62; c++) begin
            pc = c < 26 ? 8'("A" + c) : c < 52 ? 8'("a" + c - 26) : 8'("0" + c - 52);
            n  = c < 26 ? c : c < 52 ? c - 26 : c - 26;
            ep = c < 52 ? 8'("a" + n) : pc;
            step(1'b1, {m_row[n / 6], m_col[n % 6]}, "chain");
            chk("chain_exp", ptxt_char, ep);
            chk("chain_ready", 8'(ptxt_ready), 8'd1);
        end

        do_reset("reset4");
        install("ABCDEFGHIJKL");
        for (int s = 0; s < 3; s++) step(1'b1, hello_c[s], "pre_rst");
        ctxt_valid = 1'b1;
        ctxt_str = "ED";
        do_reset("midrst");
        install("ABCDEFGHIJKL");
        step(1'b1, "KL", "post_rst");
        chk("post_rst_exp", ptxt_char, "h");

        for (int r = 0; r < 4; r++) begin
            do_reset("rnd_reset");
            for (int t = 0; t < 12; t++) begin
                k = rand_key();
                case ($urandom_range(0, 3))
                    0: k = '0;
                    1: k[$urandom_range(0, 11)] = bad_chars[$urandom_range(0, 7)];
                    2: k[$urandom_range(0, 5)] = k[$urandom_range(6, 11)];
                    default: k = {$urandom, $urandom, $urandom};
                endcase
                key = k;
                step(1'(($urandom & 1)), 16'($urandom), "rnd_nokey");
            end
            key = rand_key();
            step(1'b0, 16'h0000, "rnd_install");
            for (int t = 0; t < 150; t++) begin
                key = {$urandom, $urandom, $urandom};
                case ($urandom_range(0, 3))
                    0, 1: ctxt_str = {m_row[$urandom_range(0, 5)], m_col[$urandom_range(0, 5)]};
                    2: ctxt_str = {m_col[$urandom_range(0, 5)], m_row[$urandom_range(0, 5)]};
                    default: ctxt_str = 16'($urandom);
                endcase
                step(1'($urandom_range(0, 4) != 0), ctxt_str, "rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
